// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, constants and compare helper for the PWM block.
// No ports; imported by pwm_timebase and pwm_peripheral.
package pwm_pkg;

  localparam int NUM_OUT = 16;
  localparam int DUTY_W  = 8;

  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;

  typedef logic [NUM_OUT-1:0] chan_mask_t;

  // Full-scale duty is forced high so 0xFF never dips at count 255.
  function automatic logic pwm_level(
    input logic [DUTY_W-1:0] cnt,
    input logic [DUTY_W-1:0] duty
  );
    return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus 8-bit PWM counter and period-start strobe.
// clk, rst_n in; pwm_cnt, tick, ps out (tick/ps combinational).
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE_DIV = 3000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DUTY_W-1:0] pwm_cnt,
  output logic              tick,
  output logic              ps
);

  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

  logic [PW-1:0] pre_cnt;

  // With PRESCALE_DIV=1 pre_cnt stays 0 and tick is constant 1.
  assign tick = (pre_cnt == PW'(PRESCALE_DIV - 1));
  assign ps   = (pre_cnt == '0) && (pwm_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 outputs, each forced low, forced high or shared PWM.
// clk, rst_n, en_reg_*, pwm_duty_cycle in; out[15:0], period_start out.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE_DIV = 3000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         en_reg_out_7_0,
  input  logic [7:0]         en_reg_out_15_8,
  input  logic [7:0]         en_reg_pwm_7_0,
  input  logic [7:0]         en_reg_pwm_15_8,
  input  logic [DUTY_W-1:0]  pwm_duty_cycle,
  output logic [NUM_OUT-1:0] out,
  output logic               period_start
);

  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] duty_shadow;
  logic [DUTY_W-1:0] eff_duty;
  logic              tick_unused;
  logic              ps;
  logic              pwm_raw;
  chan_mask_t        en_out;
  chan_mask_t        en_pwm;
  chan_mask_t        out_nxt;

  pwm_timebase #(
    .PRESCALE_DIV (PRESCALE_DIV)
  ) u_timebase (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_cnt (pwm_cnt),
    .tick    (tick_unused),
    .ps      (ps)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // At the boundary the new duty is used directly, so the first
  // count of a period already reflects the freshly latched value.
  assign eff_duty = ps ? pwm_duty_cycle : duty_shadow;
  assign pwm_raw  = pwm_level(pwm_cnt, eff_duty);

  // Enable dominates; PWM-mode channels follow pwm_raw, others go high.
  assign out_nxt = en_out & (~en_pwm | {NUM_OUT{pwm_raw}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_shadow  <= '0;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      if (ps) begin
        duty_shadow <= pwm_duty_cycle;
      end
      out          <= out_nxt;
      period_start <= ps;
    end
  end

endmodule
